// File: rtl/seg7_4d_disp_sched.sv
// Two-requester scheduler feeding a 4-digit hex display: round-robin accept, minimum dwell per word.
// Optional blank gap between words is enabled by defining SEG7_SCHED_BLANK_EN.
module seg7_4d_disp_sched #(
  parameter int DWELL_BITS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] d0,
  input  logic [3:0]  dp0,
  input  logic        sign0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [15:0] d1,
  input  logic [3:0]  dp1,
  input  logic        sign1,
  output logic        gnt1,
  output logic [15:0] d,
  output logic [3:0]  dp,
  output logic        sign,
  output logic        src,
  output logic        busy,
  output logic        blank
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    READY = 2'd2,
    BLANK = 2'd3
  } state_t;

  localparam logic [DWELL_BITS-1:0] DWELL_MAX = '1;
`ifdef SEG7_SCHED_BLANK_EN
  localparam logic [DWELL_BITS-1:0] GAP_MAX =
    DWELL_BITS'((64'd1 << (DWELL_BITS - 2)) - 64'd1);
`endif

  state_t                  state_q, state_d;
  logic [DWELL_BITS-1:0]   timer_q, timer_d;
  logic                    last_q, last_d;
  logic [15:0]             d_q, d_d;
  logic [3:0]              dp_q, dp_d;
  logic                    sign_q, sign_d;
  logic                    src_q, src_d;
  logic                    gnt0_q, gnt0_d;
  logic                    gnt1_q, gnt1_d;
  logic                    busy_q, busy_d;
  logic                    blank_q, blank_d;

  logic any_req;
  logic winner;
  logic accept;

  always_comb begin
    any_req = req0 | req1;
    // Contested requests go to whoever was not served last.
    winner  = (req0 & req1) ? ~last_q : req1;

    state_d = state_q;
    timer_d = timer_q;
    last_d  = last_q;
    d_d     = d_q;
    dp_d    = dp_q;
    sign_d  = sign_q;
    src_d   = src_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    accept  = 1'b0;

    case (state_q)
      IDLE: accept = any_req;
      SHOW: begin
        if (timer_q == DWELL_MAX) begin
          state_d = READY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + DWELL_BITS'(1);
        end
      end
      READY: begin
`ifdef SEG7_SCHED_BLANK_EN
        if (any_req) begin
          state_d = BLANK;
          timer_d = '0;
          d_d     = '0;
          dp_d    = '0;
          sign_d  = 1'b0;
        end
`else
        accept = any_req;
`endif
      end
`ifdef SEG7_SCHED_BLANK_EN
      BLANK: begin
        if (timer_q == GAP_MAX) begin
          timer_d = '0;
          accept  = any_req;
          state_d = READY;
        end else begin
          timer_d = timer_q + DWELL_BITS'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = SHOW;
      timer_d = '0;
      last_d  = winner;
      src_d   = winner;
      d_d     = winner ? d1 : d0;
      dp_d    = winner ? dp1 : dp0;
      sign_d  = winner ? sign1 : sign0;
      gnt0_d  = ~winner;
      gnt1_d  = winner;
    end

    busy_d  = (state_d == SHOW) || (state_d == BLANK);
    blank_d = (state_d == BLANK);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      last_q  <= 1'b1;
      d_q     <= '0;
      dp_q    <= '0;
      sign_q  <= 1'b0;
      src_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      d_q     <= d_d;
      dp_q    <= dp_d;
      sign_q  <= sign_d;
      src_q   <= src_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      blank_q <= blank_d;
    end
  end

  assign d    = d_q;
  assign dp   = dp_q;
  assign sign = sign_q;
  assign src  = src_q;
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = busy_q;
`ifdef SEG7_SCHED_BLANK_EN
  assign blank = blank_q;
`else
  assign blank = 1'b0;
  logic unused_blank;
  assign unused_blank = blank_q;
`endif

endmodule

// File: tb/tb_seg7_4d_disp_sched.sv
// Randomized + directed bench for seg7_4d_disp_sched: a behavioural model predicts grants
// into a scoreboard queue; an independent negedge monitor pops and compares DUT outputs.
module tb_seg7_4d_disp_sched;
  localparam int DB    = 4;
  localparam int DWELL = 16;
  localparam int GAP   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, req1, sign0, sign1;
  logic [15:0] d0, d1;
  logic [3:0]  dp0, dp1;
  logic        gnt0, gnt1, sign, src, busy, blank;
  logic [15:0] d;
  logic [3:0]  dp;

  seg7_4d_disp_sched #(.DWELL_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .d0(d0), .dp0(dp0), .sign0(sign0), .gnt0(gnt0),
    .req1(req1), .d1(d1), .dp1(dp1), .sign1(sign1), .gnt1(gnt1),
    .d(d), .dp(dp), .sign(sign), .src(src), .busy(busy), .blank(blank)
  );

  typedef struct {
    bit        g1;
    bit [15:0] d;
    bit [3:0]  dp;
    bit        sign;
    int        cyc;
  } grant_t;
  grant_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Model: "has anything been shown", cycles since last accept, cycles into the gap.
  bit        m_started, m_last, m_g0, m_g1, m_sign, m_src, mon_en;
  int        m_since, m_gap, cyc;
  bit [15:0] m_d;
  bit [3:0]  m_dp;

  bit hold0, hold1, pulse0, pulse1, rnd_en, rnd_data;

  task automatic model_step();
    bit any, w, acc;
    grant_t g;
    cyc++;
    m_g0 = 0;
    m_g1 = 0;
    if (!reset) begin
      m_started = 0; m_last = 1; m_since = 0; m_gap = 0;
      m_d = 0; m_dp = 0; m_sign = 0; m_src = 0;
      mon_en = 1;
      return;
    end
    any = req0 || req1;
    acc = 0;
    if (!m_started) acc = any;
    else if (m_gap > 0) begin
      if (m_gap == GAP) begin
        m_gap = 0;
        acc = any;
      end else m_gap++;
    end else if (m_since < DWELL) m_since++;
    else if (any) begin
`ifdef SEG7_SCHED_BLANK_EN
      m_gap = 1; m_d = 0; m_dp = 0; m_sign = 0;
`else
      acc = 1;
`endif
    end
    if (acc) begin
      w = (req0 && req1) ? !m_last : req1;
      m_started = 1; m_since = 0; m_last = w; m_src = w;
      m_d = w ? d1 : d0; m_dp = w ? dp1 : dp0; m_sign = w ? sign1 : sign0;
      m_g0 = !w; m_g1 = w;
      g.g1 = w; g.d = m_d; g.dp = m_dp; g.sign = m_sign; g.cyc = cyc;
      exp_q.push_back(g);
    end
  endtask

  task automatic drive();
    if (gnt0 === 1'b1) req0 = 0;
    else if (!req0 && (hold0 || pulse0 || (rnd_en && $urandom_range(0, 9) == 0))) begin
      req0 = 1;
      if (rnd_data) begin
        d0 = 16'($urandom); dp0 = 4'($urandom); sign0 = 1'($urandom);
      end else begin
        d0 = 16'h1234; dp0 = 4'b0100; sign0 = 1'b0;
      end
    end
    if (gnt1 === 1'b1) req1 = 0;
    else if (!req1 && (hold1 || pulse1 || (rnd_en && $urandom_range(0, 9) == 0))) begin
      req1 = 1;
      if (rnd_data) begin
        d1 = 16'($urandom); dp1 = 4'($urandom); sign1 = 1'($urandom);
      end else begin
        d1 = 16'hABCD; dp1 = 4'b0001; sign1 = 1'b1;
      end
    end
    pulse0 = 0;
    pulse1 = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      drive();
    end
  endtask

  // Monitor: per-cycle output check plus scoreboard pop on every grant pulse.
  initial begin
    logic [25:0] act_v, exp_v;
    grant_t g;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        act_v = {busy, blank, gnt0, gnt1, src, sign, dp, d};
        exp_v = {m_started && (m_since < DWELL || m_gap > 0), m_gap > 0,
                 m_g0, m_g1, m_src, m_sign, m_dp, m_d};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL outputs cyc=%0d actual=%h required=%h", cyc, act_v, exp_v);
        end
        if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL grant_unexpected cyc=%0d actual gnt0=%b gnt1=%b required none",
                     cyc, gnt0, gnt1);
          end else begin
            g = exp_q.pop_front();
            if (gnt1 !== g.g1 || gnt0 !== !g.g1 || src !== g.g1 || d !== g.d ||
                dp !== g.dp || sign !== g.sign || cyc != g.cyc) begin
              failures++;
              $display("FAIL grant cyc=%0d actual g1=%b d=%h dp=%h s=%b required g1=%b d=%h dp=%h s=%b cyc=%0d",
                       cyc, gnt1, d, dp, sign, g.g1, g.d, g.dp, g.sign, g.cyc);
            end else
              $display("grant cyc=%0d src=%0d d=%h dp=%b sign=%b ok", cyc, g.g1, g.d, g.dp, g.sign);
          end
        end
      end
    end
  end

  initial begin
    reset = 0;
    req0 = 0; req1 = 0; d0 = 0; d1 = 0; dp0 = 0; dp1 = 0; sign0 = 0; sign1 = 0;
    hold0 = 0; hold1 = 0; pulse0 = 0; pulse1 = 0; rnd_en = 0; rnd_data = 0;
    cyc = 0; mon_en = 0;

    tick(2);                          // reset values
    reset = 1;
    pulse0 = 1; tick(30);             // single request, full dwell, then hold

    reset = 0; tick(1); reset = 1;    // contest from IDLE
    pulse0 = 1; pulse1 = 1; tick(50);

    pulse0 = 1; tick(5);              // req1 arrives mid-dwell
    pulse1 = 1; tick(45);

    reset = 0; tick(1); reset = 1;    // reset mid-dwell, held req1 served first
    pulse0 = 1; tick(2);
    pulse1 = 1; tick(6);
    reset = 0; tick(1); reset = 1;
    tick(30);

    hold0 = 1; hold1 = 1; tick(4 * (DWELL + 1 + GAP) + 4);   // continuous contention
    hold0 = 0; hold1 = 0; tick(50);

    rnd_en = 1; rnd_data = 1;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 0; tick(1); reset = 1;
      end else tick(1);
    end
    rnd_en = 0;
    tick(2 * (DWELL + 1 + GAP) + 10);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL grants_missing actual_pending=%0d required=0", exp_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
